fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter sharing one FIFO instance among `NUM_REQ` producers. It sits directly in front of the FIFO write side and owns `wr_en`/`data_in`. It throttles on `full`/`almostfull` so that no granted beat can overflow, and routes the FIFO's `wr_ack`/`overflow` responses back to the producer that issued each beat.

---
 rtl/fifo_wr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter that lets NUM_REQ producers share one FIFO write side.
// Define FIFO_ARB_BURST_EN to let a winner keep the port for up to MAX_BURST consecutive beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            err,
    output logic                          err_sticky,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [ID_W-1:0] id_t;

    id_t                   rr_ptr;
    id_t                   rr_winner;
    id_t                   cand;
    id_t                   sel_id;
    id_t                   id1;
    id_t                   id2;
    logic                  rr_found;
    logic                  sel_valid;
    logic                  can_issue;
    logic                  xfer;
    logic                  v1;
    logic                  v2;
    logic [FIFO_WIDTH-1:0] beat;

    // A beat already on fifo_wr_en may consume the last slot, so almostfull blocks a second one.
    assign can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en);
    assign xfer      = can_issue && sel_valid;

    always_comb begin
        rr_winner = rr_ptr;
        rr_found  = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = id_t'((int'(rr_ptr) + k) % NUM_REQ);
            if (!rr_found && req[cand]) begin
                rr_winner = cand;
                rr_found  = 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state;
    state_t             state_next;
    id_t                owner;
    id_t                owner_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    // While the owner keeps requesting it holds the port; once it drops, round-robin takes over.
    always_comb begin
        sel_id    = rr_winner;
        sel_valid = rr_found;
        if (state == LOCKED && req[owner]) begin
            sel_id    = owner;
            sel_valid = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        count_next = count;
        case (state)
            IDLE: begin
                if (xfer) begin
                    owner_next = sel_id;
                    count_next = CNT_W'(1);
                    state_next = (MAX_BURST > 1) ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (!req[owner]) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (xfer) begin
                    if (count + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            count <= count_next;
        end
    end
`else
    always_comb begin
        sel_id    = rr_winner;
        sel_valid = rr_found;
    end
`endif

    always_comb begin
        beat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_id == id_t'(i)) begin
                beat = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // Responses are steered by the id that left the pipeline this cycle; stray status is dropped.
    always_comb begin
        gnt = '0;
        ack = '0;
        err = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = xfer && (sel_id == id_t'(i));
            ack[i] = fifo_wr_ack && v2 && (id2 == id_t'(i));
            err[i] = fifo_overflow && v2 && (id2 == id_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            rr_ptr       <= id_t'(NUM_REQ - 1);
            v1           <= 1'b0;
            v2           <= 1'b0;
            id1          <= '0;
            id2          <= '0;
            err_sticky   <= 1'b0;
        end else begin
            fifo_wr_en <= xfer;
            v1         <= xfer;
            v2         <= v1;
            id2        <= id1;
            if (xfer) begin
                fifo_data_in <= beat;
                rr_ptr       <= sel_id;
                id1          <= sel_id;
            end
            if (|err) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small depth-8 FIFO status model.
// Expected grant orders switch on FIFO_ARB_BURST_EN to match the build.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int FIFO_WIDTH = 16;
    localparam int MAX_BURST  = 4;
    localparam int DEPTH      = 8;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            err;
    logic                          err_sticky;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;

    logic       drain;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] m_count;
    logic       m_ack;
    logic       m_ovf;
    logic       ovr;
    logic       o_full;
    logic       o_af;
    logic       o_ack;
    logic       o_ovf;

    int n_checks;
    int n_fail;
    int n_xfer;
    int order[8];

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_WIDTH (FIFO_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .gnt             (gnt),
        .ack             (ack),
        .err             (err),
        .err_sticky      (err_sticky),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_overflow   (fifo_overflow),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: writes land at the edge after wr_en and are acknowledged the cycle after that.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_count <= '0;
            m_ack   <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (load) begin
            m_count <= load_val;
            m_ack   <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            m_ack   <= fifo_wr_en && (m_count < 4'(DEPTH));
            m_ovf   <= fifo_wr_en && (m_count == 4'(DEPTH));
            m_count <= m_count
                     + (((fifo_wr_en && (m_count < 4'(DEPTH)))) ? 4'd1 : 4'd0)
                     - ((drain && (m_count != 4'd0)) ? 4'd1 : 4'd0);
        end
    end

    assign fifo_full       = ovr ? o_full : (m_count == 4'(DEPTH));
    assign fifo_almostfull = ovr ? o_af   : (m_count >= 4'(DEPTH - 1));
    assign fifo_wr_ack     = ovr ? o_ack  : m_ack;
    assign fifo_overflow   = ovr ? o_ovf  : m_ovf;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [FIFO_WIDTH-1:0] base);
        req = r;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = base + FIFO_WIDTH'(i);
        end
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus('0, '0);
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_xfer   = 0;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        drain    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        ovr      = 1'b0;
        o_full   = 1'b0;
        o_af     = 1'b0;
        o_ack    = 1'b0;
        o_ovf    = 1'b0;
`ifdef FIFO_ARB_BURST_EN
        order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

        nextCycle();
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("rst_wr_en",  32'(fifo_wr_en),   0);
        checkOutput("rst_data",   32'(fifo_data_in), 0);
        checkOutput("rst_gnt",    32'(gnt),          0);
        checkOutput("rst_ack",    32'(ack),          0);
        checkOutput("rst_err",    32'(err),          0);
        checkOutput("rst_sticky", 32'(err_sticky),   0);

        // Single producer streaming four beats into a draining FIFO.
        drain = 1'b1;
        for (int k = 0; k < 7; k++) begin
            applyStimulus((k < 4) ? 4'b0001 : 4'b0000, 16'hA001 + 16'(k));
            checkOutput("t1_gnt",   32'(gnt), (k < 4) ? 1 : 0);
            checkOutput("t1_wr_en", 32'(fifo_wr_en), (k >= 1 && k <= 4) ? 1 : 0);
            checkOutput("t1_data",  32'(fifo_data_in),
                        (k == 0) ? 0 : 32'h0000_A001 + ((k > 4) ? 3 : k - 1));
            checkOutput("t1_ack",   32'(ack), (k >= 2 && k <= 5) ? 1 : 0);
            nextCycle();
        end

        // All producers requesting continuously.
        doReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k < 8) ? 4'b1111 : 4'b0000, 16'h1000);
            if (k < 8) begin
                checkOutput("t2_gnt", 32'(gnt), 32'(1) << order[k]);
            end
            if (k >= 1 && k <= 8) begin
                checkOutput("t2_data", 32'(fifo_data_in), 32'h0000_1000 + order[k-1]);
            end
            if (k >= 2) begin
                checkOutput("t2_ack", 32'(ack), 32'(1) << order[k-2]);
            end
            nextCycle();
        end

        // FIFO pre-filled to DEPTH-1 with no reads: exactly one more beat may issue.
        doReset();
        drain    = 1'b0;
        load_val = 4'(DEPTH - 1);
        load     = 1'b1;
        applyStimulus('0, '0);
        nextCycle();
        load   = 1'b0;
        n_xfer = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0011, 16'h3000);
            checkOutput("t3_gnt", 32'(gnt), (k == 0) ? 1 : 0);
            checkOutput("t3_ovf", 32'(fifo_overflow), 0);
            if (k == 2) begin
                checkOutput("t3_ack", 32'(ack), 1);
            end
            if ((req & gnt) != '0) begin
                n_xfer++;
            end
            nextCycle();
        end
        checkOutput("t3_xfers", 32'(n_xfer), 1);

        // Misreported overflow on producer 2's beat.
        doReset();
        ovr = 1'b1;
        applyStimulus(4'b0100, 16'h2220);
        checkOutput("t4_gnt", 32'(gnt), 32'b0100);
        nextCycle();
        applyStimulus('0, '0);
        checkOutput("t4_wr_en", 32'(fifo_wr_en), 1);
        checkOutput("t4_data",  32'(fifo_data_in), 32'h0000_2222);
        nextCycle();
        o_ovf = 1'b1;
        o_ack = 1'b0;
        applyStimulus('0, '0);
        checkOutput("t4_err",        32'(err), 32'b0100);
        checkOutput("t4_ack",        32'(ack), 0);
        checkOutput("t4_sticky_pre", 32'(err_sticky), 0);
        nextCycle();
        o_ovf = 1'b0;
        o_ack = 1'b1;
        applyStimulus('0, '0);
        checkOutput("t4_err_pulse", 32'(err), 0);
        checkOutput("t4_stray_ack", 32'(ack), 0);
        checkOutput("t4_sticky",    32'(err_sticky), 1);
        nextCycle();
        o_ack = 1'b0;
        applyStimulus('0, '0);
        checkOutput("t4_sticky_hold", 32'(err_sticky), 1);
        doReset();
        #1;
        checkOutput("t4_sticky_clr", 32'(err_sticky), 0);

        // Reset while a beat is in flight; wr_ack is held high so any surviving id would show.
        o_ack = 1'b1;
        applyStimulus(4'b0100, 16'h5550);
        checkOutput("t5_gnt", 32'(gnt), 32'b0100);
        nextCycle();
        rst = 1'b1;
        applyStimulus('0, '0);
        checkOutput("t5_inflight", 32'(fifo_wr_en), 1);
        nextCycle();
        rst = 1'b0;
        applyStimulus('0, '0);
        checkOutput("t5_wr_en", 32'(fifo_wr_en), 0);
        checkOutput("t5_ack",   32'(ack), 0);
        nextCycle();
        applyStimulus(4'b1111, 16'h6000);
        checkOutput("t5_ack_late", 32'(ack), 0);
        checkOutput("t5_gnt_next", 32'(gnt), 32'b0001);
        nextCycle();
        o_ack = 1'b0;
        ovr   = 1'b0;
        applyStimulus('0, '0);

        // Producers 1 and 3; producer 1 drops after two beats.
        doReset();
        drain = 1'b1;
        applyStimulus(4'b1010, 16'h7000);
        checkOutput("t6_gnt0", 32'(gnt), 32'b0010);
        nextCycle();
        applyStimulus(4'b1010, 16'h7000);
`ifdef FIFO_ARB_BURST_EN
        checkOutput("t6_gnt1", 32'(gnt), 32'b0010);
`else
        checkOutput("t6_gnt1", 32'(gnt), 32'b1000);
`endif
        nextCycle();
        applyStimulus(4'b1000, 16'h7000);
        checkOutput("t6_gnt2", 32'(gnt), 32'b1000);
        nextCycle();
        applyStimulus('0, '0);
        checkOutput("t6_data", 32'(fifo_data_in), 32'h0000_7003);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
